pipelined_adder_nbit: RTL

//  Parametrised, pipelined N-bit adder/subtractor; next generation of the 16/32-bit ripple adders.

---
 rtl/adder_pkg.sv | 25 ++
 rtl/adder_slice.sv | 29 ++
 rtl/pipelined_adder_nbit.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : adder_pkg                                                  |
// | Shared mode encodings, stage record and depth helper for the adders. |
// | Rev     : 1.0                                                        |
// +----------------------------------------------------------------------+
package adder_pkg;

  localparam logic MODE_ADD   = 1'b0;
  localparam logic MODE_SUB   = 1'b1;
  localparam int   MAX_NSLICE = 8;

  // Width-independent part of a stage; the partial sum and pending operand
  // bits depend on WIDTH/SLICE and are held next to it in the pipeline.
  typedef struct packed {
    logic valid;
    logic carry;
  } stage_rec_t;

  function automatic int nslice(input int width, input int slice);
    return width / slice;
  endfunction

endpackage
`default_nettype wire

// File: rtl/adder_slice.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : adder_slice                                                 |
// | SLICE-bit combinational adder with carry out and carry into the MSB. |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module adder_slice
  import adder_pkg::*;
#(
  parameter int SLICE = 16
) (
  input  logic [SLICE-1:0] i_a,
  input  logic [SLICE-1:0] i_b,
  input  logic             i_cin,
  output logic [SLICE-1:0] o_sum,
  output logic             o_cout,
  output logic             o_cmsb
);

  logic [SLICE:0] w_total;

  assign w_total = {1'b0, i_a} + {1'b0, i_b} + {{SLICE{1'b0}}, i_cin};
  assign o_sum   = w_total[SLICE-1:0];
  assign o_cout  = w_total[SLICE];
  // Sum MSB = a ^ b ^ carry-in, so the carry into the MSB falls out directly.
  assign o_cmsb  = i_a[SLICE-1] ^ i_b[SLICE-1] ^ w_total[SLICE-1];

endmodule
`default_nettype wire

// File: rtl/pipelined_adder_nbit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : pipelined_adder_nbit                                        |
// | Pipelined WIDTH-bit add/subtract, SLICE bits per registered stage,   |
// | valid/ready on both sides, signed-overflow flag.                     |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module pipelined_adder_nbit
  import adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Overflow
);

  localparam int c_nslice = nslice(WIDTH, SLICE);

  if ((WIDTH % SLICE) != 0 || c_nslice < 1 || c_nslice > MAX_NSLICE) begin : g_param_check
    $error("pipelined_adder_nbit: WIDTH must be a multiple of SLICE with 1..8 slices");
  end

  logic             w_advance;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_cin0;

  // Whole pipeline moves in lockstep; bubbles are deliberately not collapsed.
  assign w_advance = ~OutValid | OutReady;
  assign InReady   = w_advance;
  assign w_b_eff   = (Sub == MODE_ADD) ? B : ~B;
  assign w_cin0    = (Sub == MODE_SUB) ? 1'b1 : Cin;

  for (genvar k = 0; k < c_nslice; k++) begin : g_stage
    localparam int c_done = (k + 1) * SLICE;
    localparam bit c_last = (k == c_nslice - 1);

    logic [SLICE-1:0]  w_a_sl;
    logic [SLICE-1:0]  w_b_sl;
    logic [SLICE-1:0]  w_sum_sl;
    logic              w_cin;
    logic              w_vin;
    logic              w_cout;
    logic              w_cmsb;
    logic [c_done-1:0] w_sum_nxt;
    stage_rec_t        r_rec;
    logic [c_done-1:0] r_sum;

    if (k == 0) begin : g_head
      assign w_a_sl    = A[SLICE-1:0];
      assign w_b_sl    = w_b_eff[SLICE-1:0];
      assign w_cin     = w_cin0;
      assign w_vin     = InValid;
      assign w_sum_nxt = w_sum_sl;
    end else begin : g_body
      assign w_a_sl    = g_stage[k-1].g_mid.r_a[SLICE-1:0];
      assign w_b_sl    = g_stage[k-1].g_mid.r_b[SLICE-1:0];
      assign w_cin     = g_stage[k-1].r_rec.carry;
      assign w_vin     = g_stage[k-1].r_rec.valid;
      assign w_sum_nxt = {w_sum_sl, g_stage[k-1].r_sum};
    end

    adder_slice #(
      .SLICE (SLICE)
    ) u_slice (
      .i_a    (w_a_sl),
      .i_b    (w_b_sl),
      .i_cin  (w_cin),
      .o_sum  (w_sum_sl),
      .o_cout (w_cout),
      .o_cmsb (w_cmsb)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
        r_rec <= '0;
        r_sum <= '0;
      end else if (w_advance) begin
        r_rec.valid <= w_vin;
        r_rec.carry <= w_cout;
        r_sum       <= w_sum_nxt;
      end
    end

    if (c_last) begin : g_tail
      logic r_ovf;

      always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
          r_ovf <= 1'b0;
        end else if (w_advance) begin
          r_ovf <= w_cout ^ w_cmsb;
        end
      end
    end else begin : g_mid
      // Pending operand bits are kept right-aligned: the next slice is always [SLICE-1:0].
      localparam int c_pend = WIDTH - c_done;

      logic [c_pend-1:0] r_a;
      logic [c_pend-1:0] r_b;
      logic [c_pend-1:0] w_a_nxt;
      logic [c_pend-1:0] w_b_nxt;
      logic              w_cmsb_unused;

      assign w_cmsb_unused = w_cmsb;

      if (k == 0) begin : g_src_in
        assign w_a_nxt = A[WIDTH-1:SLICE];
        assign w_b_nxt = w_b_eff[WIDTH-1:SLICE];
      end else begin : g_src_prev
        assign w_a_nxt = g_stage[k-1].g_mid.r_a[c_pend+SLICE-1:SLICE];
        assign w_b_nxt = g_stage[k-1].g_mid.r_b[c_pend+SLICE-1:SLICE];
      end

      always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_advance) begin
          r_a <= w_a_nxt;
          r_b <= w_b_nxt;
        end
      end
    end
  end

  assign OutValid = g_stage[c_nslice-1].r_rec.valid;
  assign Cout     = g_stage[c_nslice-1].r_rec.carry;
  assign Sum      = g_stage[c_nslice-1].r_sum;
  assign Overflow = g_stage[c_nslice-1].g_tail.r_ovf;

endmodule
`default_nettype wire
